// File: rtl/game_pkg.sv
// Shared match-sequencer types and playfield/goal geometry for game_ctl, draw_ball_ctl and the score overlay.
// GAME_CTL_PAUSE_EN adds the PAUSE state code.
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_GOAL      = 3'd3,
`ifdef GAME_CTL_PAUSE_EN
    ST_GAME_OVER = 3'd4,
    ST_PAUSE     = 3'd5
`else
    ST_GAME_OVER = 3'd4
`endif
  } state_t;

  localparam int SCREEN_W         = 1024;
  localparam int SCREEN_H         = 768;
  localparam int DEF_GOAL_X_LEFT  = 20;
  localparam int DEF_GOAL_X_RIGHT = 1003;
  localparam int DEF_GOAL_Y_TOP   = 284;
  localparam int DEF_GOAL_Y_BOT   = 484;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/game_ctl_edge_det.sv
// Input register followed by rising-edge detection; pulse is one clock wide.
module edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic pulse
);

  logic sig_q;
  logic sig_qq;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sig_q  <= 1'b0;
      sig_qq <= 1'b0;
    end else begin
      sig_q  <= sig_in;
      sig_qq <= sig_q;
    end
  end

  assign pulse = sig_q & ~sig_qq;

endmodule

// File: rtl/game_ctl.sv
// Frame-synchronous air hockey match sequencer: serve, play, goal hold, game over.
// Define GAME_CTL_PAUSE_EN to add the pause_in port and PAUSE state.
module game_ctl
  import game_pkg::*;
#(
  parameter int GOAL_X_LEFT      = DEF_GOAL_X_LEFT,
  parameter int GOAL_X_RIGHT     = DEF_GOAL_X_RIGHT,
  parameter int GOAL_Y_TOP       = DEF_GOAL_Y_TOP,
  parameter int GOAL_Y_BOT       = DEF_GOAL_Y_BOT,
  parameter int WIN_SCORE        = 7,
  parameter int SERVE_FRAMES     = 60,
  parameter int GOAL_HOLD_FRAMES = 120
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         vsync_in,
  input  logic         start_in,
`ifdef GAME_CTL_PAUSE_EN
  input  logic         pause_in,
`endif
  input  logic [11:0]  ball_xpos,
  input  logic [11:0]  ball_ypos,
  output logic         ball_freeze,
  output logic         ball_reset,
  output logic         serve_dir,
  output logic [3:0]   score_p1,
  output logic [3:0]   score_p2,
  output logic         game_over,
  output logic         winner,
  output logic [STATE_W-1:0] state_out
);

  localparam logic [11:0] X_L   = 12'(GOAL_X_LEFT);
  localparam logic [11:0] X_R   = 12'(GOAL_X_RIGHT);
  localparam logic [11:0] Y_T   = 12'(GOAL_Y_TOP);
  localparam logic [11:0] Y_B   = 12'(GOAL_Y_BOT);
  localparam logic [3:0]  WIN   = 4'(WIN_SCORE);
  localparam logic [8:0]  SERVE_LIM = 9'(SERVE_FRAMES);
  localparam logic [8:0]  HOLD_LIM  = 9'(GOAL_HOLD_FRAMES);

  state_t     state;
  logic [7:0] frame_cnt;
  logic       tick;
  logic       start_pulse;
  logic       in_mouth;
  logic       goal_left;
  logic       goal_right;
  logic       count_done;

  edge_det u_vsync (.clk_in(clk_in), .rst(rst), .sig_in(vsync_in), .pulse(tick));
  edge_det u_start (.clk_in(clk_in), .rst(rst), .sig_in(start_in), .pulse(start_pulse));

`ifdef GAME_CTL_PAUSE_EN
  logic pause_pulse;
  edge_det u_pause (.clk_in(clk_in), .rst(rst), .sig_in(pause_in), .pulse(pause_pulse));
`endif

  // count_done is true on the tick that completes the phase (limit 0 exits on first tick)
  always_comb begin
    in_mouth   = (ball_ypos >= Y_T) && (ball_ypos <= Y_B);
    goal_left  = (ball_xpos <= X_L) && in_mouth;
    goal_right = (ball_xpos >= X_R) && in_mouth;
    count_done = ({1'b0, frame_cnt} + 9'd1) >= ((state == ST_SERVE) ? SERVE_LIM : HOLD_LIM);
  end

  assign state_out = state;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      ball_freeze <= 1'b1;
      ball_reset  <= 1'b0;
      serve_dir   <= 1'b0;
      score_p1    <= '0;
      score_p2    <= '0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          ball_freeze <= 1'b1;
          if (start_pulse) begin
            score_p1   <= '0;
            score_p2   <= '0;
            state      <= ST_SERVE;
            frame_cnt  <= '0;
            ball_reset <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (tick) begin
            if (count_done) begin
              state       <= ST_PLAY;
              frame_cnt   <= '0;
              ball_freeze <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        ST_PLAY: begin
`ifdef GAME_CTL_PAUSE_EN
          if (pause_pulse) begin
            state       <= ST_PAUSE;
            frame_cnt   <= '0;
            ball_freeze <= 1'b1;
          end else
`endif
          if (tick && goal_left) begin
            score_p2    <= sat_inc4(score_p2);
            serve_dir   <= 1'b0;
            state       <= ST_GOAL;
            frame_cnt   <= '0;
            ball_freeze <= 1'b1;
          end else if (tick && goal_right) begin
            score_p1    <= sat_inc4(score_p1);
            serve_dir   <= 1'b1;
            state       <= ST_GOAL;
            frame_cnt   <= '0;
            ball_freeze <= 1'b1;
          end
        end
        ST_GOAL: begin
          if (tick) begin
            if (count_done) begin
              frame_cnt <= '0;
              if (score_p1 == WIN || score_p2 == WIN) begin
                state     <= ST_GAME_OVER;
                game_over <= 1'b1;
                winner    <= (score_p2 == WIN);
              end else begin
                state      <= ST_SERVE;
                ball_reset <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        ST_GAME_OVER: begin
          if (start_pulse) begin
            score_p1   <= '0;
            score_p2   <= '0;
            game_over  <= 1'b0;
            state      <= ST_SERVE;
            frame_cnt  <= '0;
            ball_reset <= 1'b1;
          end
        end
`ifdef GAME_CTL_PAUSE_EN
        ST_PAUSE: begin
          if (pause_pulse) begin
            state       <= ST_PLAY;
            frame_cnt   <= '0;
            ball_freeze <= 1'b0;
          end
        end
`endif
        default: begin
          state       <= ST_IDLE;
          frame_cnt   <= '0;
          ball_freeze <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctl.sv
// Directed bench for game_ctl: a phase-level match model checked every cycle plus literal spot checks.
module tb_game_ctl;

  localparam int P_SERVE = 60;
  localparam int P_HOLD  = 120;
  localparam int P_WIN   = 7;
  localparam int P_XL = 20, P_XR = 1003, P_YT = 284, P_YB = 484;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        vsync_in = 1'b0;
  logic        start_in = 1'b0;
  logic        pause_in = 1'b0;
  logic [11:0] ball_xpos = 12'd512;
  logic [11:0] ball_ypos = 12'd384;
  logic        ball_freeze, ball_reset, serve_dir, game_over, winner;
  logic [3:0]  score_p1, score_p2;
  logic [2:0]  state_out;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  game_ctl dut (
    .clk_in(clk_in), .rst(rst), .vsync_in(vsync_in), .start_in(start_in),
`ifdef GAME_CTL_PAUSE_EN
    .pause_in(pause_in),
`endif
    .ball_xpos(ball_xpos), .ball_ypos(ball_ypos),
    .ball_freeze(ball_freeze), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score_p1(score_p1), .score_p2(score_p2), .game_over(game_over),
    .winner(winner), .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  // 16-cycle frames, vsync high for 4
  initial begin
    forever begin
      repeat (12) @(negedge clk_in);
      vsync_in = 1'b1;
      repeat (4) @(negedge clk_in);
      vsync_in = 1'b0;
    end
  end

  // Phase-level model: 0 idle,1 serve,2 play,3 goal,4 over,5 pause
  int m_phase, m_ticks, m_p1, m_p2;
  bit m_dir, m_go, m_win, m_br;
  bit v1, v2, s1, s2, q1, q2;

  task automatic begin_serve();
    m_phase = 1; m_ticks = 0; m_br = 1;
  endtask

  initial begin
    m_phase = 0; m_ticks = 0; m_p1 = 0; m_p2 = 0;
    m_dir = 0; m_go = 0; m_win = 0; m_br = 0;
    {v1, v2, s1, s2, q1, q2} = '0;
    forever begin
      @(posedge clk_in or posedge rst);
      if (rst) begin
        m_phase = 0; m_ticks = 0; m_p1 = 0; m_p2 = 0;
        m_dir = 0; m_go = 0; m_win = 0; m_br = 0;
        {v1, v2, s1, s2, q1, q2} = '0;
      end else begin
        bit tk, st, ps, in_y;
        int x, y;
        tk = v1 && !v2; st = s1 && !s2; ps = q1 && !q2;
        v2 = v1; v1 = vsync_in; s2 = s1; s1 = start_in; q2 = q1; q1 = pause_in;
        x = int'(ball_xpos); y = int'(ball_ypos);
        in_y = (y >= P_YT) && (y <= P_YB);
        m_br = 0;
        case (m_phase)
          0: if (st) begin m_p1 = 0; m_p2 = 0; begin_serve(); end
          1: if (tk) begin
               m_ticks++;
               if (m_ticks >= P_SERVE) begin m_phase = 2; m_ticks = 0; end
             end
          2: begin
`ifdef GAME_CTL_PAUSE_EN
               if (ps) m_phase = 5;
               else
`endif
               if (tk && x <= P_XL && in_y) begin
                 m_p2 = (m_p2 < 15) ? m_p2 + 1 : 15; m_dir = 0; m_phase = 3; m_ticks = 0;
               end else if (tk && x >= P_XR && in_y) begin
                 m_p1 = (m_p1 < 15) ? m_p1 + 1 : 15; m_dir = 1; m_phase = 3; m_ticks = 0;
               end
             end
          3: if (tk) begin
               m_ticks++;
               if (m_ticks >= P_HOLD) begin
                 if (m_p1 == P_WIN || m_p2 == P_WIN) begin
                   m_phase = 4; m_go = 1; m_win = (m_p2 == P_WIN);
                 end else begin_serve();
               end
             end
          4: if (st) begin m_p1 = 0; m_p2 = 0; m_go = 0; begin_serve(); end
          5: if (ps) m_phase = 2;
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (cmp_on) begin
        logic [15:0] act, exp;
        act = {ball_freeze, ball_reset, serve_dir, score_p1, score_p2, game_over, winner, state_out};
        exp = {(m_phase != 2) ? 1'b1 : 1'b0, m_br, m_dir, 4'(m_p1), 4'(m_p2), m_go, m_win, 3'(m_phase)};
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL model t=%0t {frz,brst,dir,p1,p2,go,win,st} got=%h want=%h", $time, act, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    repeat (n) @(posedge vsync_in);
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  task automatic set_ball(input int x, input int y);
    ball_xpos = 12'(x);
    ball_ypos = 12'(y);
  endtask

  task automatic start_edge();
    @(negedge clk_in);
    start_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    chk("start_reset_pulse", int'(ball_reset), 1);
    chk("start_state_serve", int'(state_out), 1);
    @(posedge clk_in);
    #1;
    chk("start_reset_done", int'(ball_reset), 0);
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    cmp_on = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_state", int'(state_out), 0);
    chk("rst_freeze", int'(ball_freeze), 1);
    chk("rst_scores", int'({score_p1, score_p2}), 0);
    chk("rst_flags", int'({ball_reset, serve_dir, game_over, winner}), 0);
    rst = 1'b0;

    wait_frames(10);
    chk("idle_10_frames", int'(state_out), 0);

    start_edge();
    wait_frames(P_SERVE);
    chk("serve_to_play", int'(state_out), 2);
    chk("play_unfrozen", int'(ball_freeze), 0);

    set_ball(10, 384);
    wait_frames(1);
    chk("left_goal_p2", int'(score_p2), 1);
    chk("left_goal_dir", int'(serve_dir), 0);
    chk("left_goal_state", int'(state_out), 3);
    set_ball(512, 384);
    wait_frames(P_HOLD);
    chk("hold_to_serve", int'(state_out), 1);
    wait_frames(P_SERVE);

    set_ball(10, 100);
    wait_frames(1);
    set_ball(1010, 600);
    wait_frames(1);
    chk("outside_mouth_state", int'(state_out), 2);
    chk("outside_mouth_scores", int'({score_p1, score_p2}), 8'h01);
    set_ball(20, 284);
    wait_frames(1);
    chk("corner_left_goal_p2", int'(score_p2), 2);
    set_ball(512, 384);
    wait_frames(P_HOLD);
    wait_frames(P_SERVE);

    for (int i = 0; i < P_WIN; i++) begin
      set_ball(1010, 384);
      wait_frames(1);
      chk("right_goal_p1", int'(score_p1), i + 1);
      chk("right_goal_dir", int'(serve_dir), 1);
      set_ball(512, 384);
      wait_frames(P_HOLD);
      if (i < P_WIN - 1) wait_frames(P_SERVE);
    end
    chk("over_state", int'(state_out), 4);
    chk("over_flag", int'(game_over), 1);
    chk("over_winner", int'(winner), 0);
    chk("over_p1", int'(score_p1), 7);

    start_edge();
    chk("restart_scores", int'({score_p1, score_p2}), 0);
    chk("restart_over_clr", int'(game_over), 0);

    wait_frames(P_SERVE);
    set_ball(10, 384);
    wait_frames(1);
    chk("goal_before_rst", int'(state_out), 3);
    set_ball(512, 384);
    wait_frames(49);
    rst = 1'b1;
    #1;
    chk("midgoal_rst_state", int'(state_out), 0);
    chk("midgoal_rst_scores", int'({score_p1, score_p2}), 0);
    chk("midgoal_rst_brst", int'(ball_reset), 0);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;

`ifdef GAME_CTL_PAUSE_EN
    wait_frames(2);
    start_edge();
    wait_frames(P_SERVE);
    @(negedge clk_in);
    pause_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("pause_freeze", int'(ball_freeze), 1);
    chk("pause_state", int'(state_out), 5);
    @(negedge clk_in);
    pause_in = 1'b0;
    set_ball(10, 384);
    wait_frames(2);
    chk("pause_no_score", int'(score_p2), 0);
    set_ball(512, 384);
    @(negedge clk_in);
    pause_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("unpause_state", int'(state_out), 2);
    @(negedge clk_in);
    pause_in = 1'b0;
`endif

    wait_frames(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
